dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-requester arbiter for the single data-memory port of the MIPS core.
- Requesters are the CPU load/store path and a debug/test port used for memory peek and poke and for preloading variables.
- It serialises accesses through a fixed FSM, stalls the CPU while its access is outstanding, and returns read data through per-port registers.
- It sits between mips datapath MemWr/ALU address/DM and mem1.

Parameters:
- AW, 16, byte-address width.
- DW, 32, data width. Fixed at 32; byte enables are 4 bits.
- MEM_LAT, 0, cycles from the ISSUE cycle to valid mem_rdata. Legal range 0..3.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- cpu_req  in  1  CPU access request; held until cpu_done.
- cpu_we  in  1  1=store, 0=load.
- cpu_be  in  4  byte enables, big-endian: be[3]=addr+0 (MSB) .. be[0]=addr+3.
- cpu_addr  in  AW  byte address.
- cpu_wdata  in  DW  store data.
- cpu_rdata  out  DW  load data register.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_stall  out  1  cpu_req & ~cpu_done (combinational); freezes PC.
- dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata  in  1/1/4/AW/DW  debug request, same rules as CPU.
- dbg_rdata  out  DW  debug read data register.
- dbg_done  out  1  one-cycle completion pulse.
- mem_en  out  1  memory access strobe.
- mem_we  out  4  per-byte write enables.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- arb_busy  out  1  state != IDLE.

Behaviour:
- Reset is asynchronous, active-high; clock is Clk.
- Reset values:
  - state=IDLE; all outputs 0.
  - cpu_rdata=dbg_rdata=0.
  - last_gnt=DBG, so the CPU wins the first tie.
  - Latched request registers are 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no request, stay.
  - If exactly one requester is asserted, grant it.
  - If both are asserted, grant the port != last_gnt.
  - On the grant edge, latch owner, we, be, addr, wdata, then go to ISSUE.
- ISSUE:
  - Drive mem_en=1, mem_addr=latched addr, mem_wdata=latched wdata.
  - mem_we = we ? be : 4'b0000.
  - If MEM_LAT==0: capture mem_rdata into the owner's rdata register and go to RESP.
  - Otherwise: load cnt=MEM_LAT-1 and go to WAIT.
- WAIT:
  - mem_en=0, mem_we=0.
  - If cnt==0: capture mem_rdata into the owner's rdata register and go to RESP.
  - Otherwise decrement cnt.
- RESP:
  - Pulse the owner's done for exactly one cycle.
  - Set last_gnt=owner, then go to IDLE.
- Only the owner's rdata register is written; the other port's register holds its value.
- Stores also capture mem_rdata, which is don't-care for stores.
- Latency: req first sampled in IDLE at cycle 0 gives done in cycle 2+MEM_LAT. Back-to-back throughput is one access per 3+MEM_LAT cycles.
- Requester rules:
  - Hold req and all fields stable until done.
  - Drop req on the edge where done is sampled.
  - The arbiter never samples req in RESP, so there are no double grants.
- Field changes after the grant edge are ignored (latched copy is used).
- be==0 is legal: no byte written, done is still returned.
- Address is passed unchanged; there is no alignment check.
- The losing requester keeps req high and is granted in the next IDLE cycle. Starvation is bounded to one access.
- Reset mid-operation:
  - Aborts to IDLE, clears done/mem_en/mem_we and the latches.
  - A write is not issued unless ISSUE had already been clocked.
  - The requester must re-issue.
- mem_en and mem_we are never asserted outside ISSUE.

Decomposition:
- Shared package (mips_pkg):
  - State encoding localparams.
  - Port IDs PORT_CPU=0, PORT_DBG=1.
  - BE_WORD=4'b1111.
- Optional sub-module arb_rr2: two-input round-robin picker (req[1:0], last → gnt).
- All sequencing stays in dm_arbiter.

Test Plan:
1. Debug store, MEM_LAT=0: dbg_req, we=1, be=1111, addr=16'hffe8, wdata=32'd7 → mem_en and mem_we=1111 for one cycle at cycle 1, dbg_done at cycle 2. A following CPU load of ffe8 gives cpu_rdata=7 at cpu_done.
2. Byte store: CPU store be=0010, addr=16'hfff0, wdata=32'h0000AB00 onto 0 → word read back = 32'h0000AB00; other bytes unchanged.
3. Simultaneous requests from reset: cpu and dbg req in the same cycle → CPU granted first, DBG next. Repeat: grant alternates CPU/DBG/CPU. cpu_stall stays 1 until cpu_done.
4. Latency sweep, MEM_LAT=0,1,3: single load → done at cycles 2, 3, 5. mem_rdata sampled exactly MEM_LAT cycles after ISSUE.
5. Reset mid-WAIT, MEM_LAT=3: assert Reset during WAIT → all outputs 0 immediately, no done pulse. The re-issued request completes normally.
6. Request fields changed after grant: change addr ffe8→ffec during WAIT → access uses ffe8; the other port's rdata is unchanged.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared state encoding, port IDs and byte-enable helpers for the data-memory arbiter
package dm_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam logic [3:0] BE_WORD = 4'b1111;
  function automatic logic [3:0] wr_mask(input logic we, input logic [3:0] be);
    return we ? be : 4'b0000;
  endfunction
endpackage

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: one requester's access port into the data-memory arbiter
interface dm_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req;
  logic          we;
  logic [3:0]    be;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          done;
  modport master (output req, we, be, addr, wdata, input rdata, done);
  modport slave (input req, we, be, addr, wdata, output rdata, done);
endinterface

// File: rtl/dm_arbiter_rr2.sv
// dm_arbiter_rr2: two-input round-robin picker; on a tie the port that was not served last wins
module dm_arbiter_rr2
  import dm_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | last == PORT_DBG);
  assign gnt[1] = req[1] & (~req[0] | last == PORT_CPU);
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: serialises CPU and debug accesses onto the single data-memory port
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int MEM_LAT = 0
) (
  input  logic          Clk,
  input  logic          Reset,
  dm_arbiter_if.slave   cpu,
  dm_arbiter_if.slave   dbg,
  output logic          cpu_stall,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          arb_busy
);
  localparam logic [1:0] LAT_INIT = 2'(MEM_LAT == 0 ? 0 : MEM_LAT - 1);
  state_t     state;
  logic       owner, last_gnt, cap;
  logic [1:0] gnt, cnt;
  dm_arbiter_rr2 u_rr (
    .req ({dbg.req, cpu.req}),
    .last(last_gnt),
    .gnt (gnt)
  );
  // mem_addr/mem_wdata double as the latched request fields
  assign cap       = (state == ISSUE && MEM_LAT == 0) || (state == WAIT && cnt == 2'd0);
  assign cpu_stall = cpu.req & ~cpu.done;
  assign arb_busy  = state != IDLE;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      state     <= IDLE;
      owner     <= PORT_CPU;
      last_gnt  <= PORT_DBG;
      cnt       <= 2'd0;
      mem_en    <= 1'b0;
      mem_we    <= 4'b0000;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu.rdata <= '0;
      dbg.rdata <= '0;
      cpu.done  <= 1'b0;
      dbg.done  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|gnt) begin
          owner     <= gnt[1];
          mem_en    <= 1'b1;
          mem_we    <= gnt[1] ? wr_mask(dbg.we, dbg.be) : wr_mask(cpu.we, cpu.be);
          mem_addr  <= gnt[1] ? dbg.addr : cpu.addr;
          mem_wdata <= gnt[1] ? dbg.wdata : cpu.wdata;
          state     <= ISSUE;
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 4'b0000;
          cnt    <= LAT_INIT;
          state  <= MEM_LAT == 0 ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd0) state <= RESP;
        end
        RESP: begin
          cpu.done <= 1'b0;
          dbg.done <= 1'b0;
          last_gnt <= owner;
          state    <= IDLE;
        end
      endcase
      if (cap) begin
        if (owner) dbg.rdata <= mem_rdata;
        else cpu.rdata <= mem_rdata;
        cpu.done <= ~owner;
        dbg.done <= owner;
      end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed checks of three arbiter instances (MEM_LAT 0, 1, 3) against byte-lane memory models
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [15:0] addr;
    logic [31:0] wd;
  } rq_t;
  logic        clk = 1'b0;
  logic [2:0]  rst;
  rq_t         cin [3];
  rq_t         din [3];
  logic [31:0] c_rd [3];
  logic [31:0] d_rd [3];
  logic        c_done [3];
  logic        d_done [3];
  logic [2:0]  stall, men, busy;
  logic [3:0]  mwe [3];
  logic [15:0] maddr [3];
  logic [31:0] mwd [3];
  logic [31:0] mrd [3];
  logic [31:0] mem [3][16];
  int          age [3];
  int          lat [3] = '{0, 1, 3};
  int          n_tests = 0, n_fail = 0;
  int          r_cyc, r_en_cyc, r_en_n;
  logic [31:0] r_rd, r_wd;
  logic [3:0]  r_we;
  logic [15:0] r_a;
  logic        r_od, seen;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : u
    dm_arbiter_if #(.AW(16), .DW(32)) ci ();
    dm_arbiter_if #(.AW(16), .DW(32)) di ();
    assign ci.req = cin[g].req;
    assign ci.we = cin[g].we;
    assign ci.be = cin[g].be;
    assign ci.addr = cin[g].addr;
    assign ci.wdata = cin[g].wd;
    assign di.req = din[g].req;
    assign di.we = din[g].we;
    assign di.be = din[g].be;
    assign di.addr = din[g].addr;
    assign di.wdata = din[g].wd;
    assign c_rd[g] = ci.rdata;
    assign c_done[g] = ci.done;
    assign d_rd[g] = di.rdata;
    assign d_done[g] = di.done;
    dm_arbiter #(.AW(16), .DW(32), .MEM_LAT(g == 0 ? 0 : (g == 1 ? 1 : 3))) dut (
      .Clk      (clk),
      .Reset    (rst[g]),
      .cpu      (ci),
      .dbg      (di),
      .cpu_stall(stall[g]),
      .mem_en   (men[g]),
      .mem_we   (mwe[g]),
      .mem_addr (maddr[g]),
      .mem_wdata(mwd[g]),
      .mem_rdata(mrd[g]),
      .arb_busy (busy[g])
    );
    // read data is only valid exactly MEM_LAT cycles after the strobe, garbage otherwise
    assign mrd[g] = ((g == 0 && men[g]) || (g != 0 && age[g] == (g == 1 ? 1 : 3)))
                    ? mem[g][maddr[g][5:2]] : 32'hDEADBEEF;
    always @(posedge clk) begin
      if (men[g])
        for (int b = 0; b < 4; b++)
          if (mwe[g][b]) mem[g][maddr[g][5:2]][b*8 +: 8] <= mwd[g][b*8 +: 8];
      age[g] <= men[g] ? 1 : ((age[g] != 0 && age[g] < 7) ? age[g] + 1 : 0);
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drv(input int i, input logic p, input rq_t r);
    if (p) din[i] = r;
    else cin[i] = r;
  endtask
  // one full access: waits for IDLE, requests, optionally retargets addr at cycle chg, drops req on done
  task automatic acc(input int i, input logic p, input logic we, input logic [3:0] be,
                     input logic [15:0] a, input logic [31:0] wd, input int chg, input logic [15:0] a2);
    for (int k = 0; k < 20 && busy[i]; k++) tick;
    drv(i, p, {1'b1, we, be, a, wd});
    r_cyc = -1; r_en_cyc = -1; r_en_n = 0; r_od = 1'b0;
    r_rd = '0; r_wd = '0; r_we = '0; r_a = '0;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if (c == chg) begin
        if (p) din[i].addr = a2;
        else cin[i].addr = a2;
      end
      if (men[i]) begin
        if (r_en_cyc < 0) r_en_cyc = c;
        r_en_n++;
        r_we = mwe[i];
        r_a = maddr[i];
        r_wd = mwd[i];
      end
      if (p ? c_done[i] : d_done[i]) r_od = 1'b1;
      if (p ? d_done[i] : c_done[i]) begin
        r_cyc = c;
        r_rd = p ? d_rd[i] : c_rd[i];
        break;
      end
    end
    drv(i, p, '0);
  endtask
  initial begin
    rst = 3'b111;
    for (int k = 0; k < 3; k++) begin
      cin[k] = '0;
      din[k] = '0;
    end
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_en", 32'(men), 0);
    chk("rst_mem_we", 32'(mwe[0]), 0);
    chk("rst_mem_addr", 32'(maddr[0]), 0);
    chk("rst_cpu_rdata", c_rd[0], 0);
    chk("rst_dbg_rdata", d_rd[2], 0);
    chk("rst_done", 32'({c_done[0], d_done[0]}), 0);
    chk("rst_stall", 32'(stall), 0);
    repeat (2) tick;
    rst = 3'b000;
    // simultaneous requests from reset: CPU, DBG, CPU
    cin[0] = {1'b1, 1'b0, BE_WORD, 16'hffe0, 32'h0};
    din[0] = {1'b1, 1'b0, BE_WORD, 16'hffe4, 32'h0};
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1) chk("tie_stall_c1", 32'(stall[0]), 1);
      if (c == 2) chk("tie_cpu_first", 32'({c_done[0], d_done[0], stall[0]}), 32'b100);
      if (c == 4) chk("tie_stall_c4", 32'(stall[0]), 1);
      if (c == 5) chk("tie_dbg_second", 32'({c_done[0], d_done[0]}), 32'b01);
      if (c == 8) begin
        chk("tie_cpu_third", 32'({c_done[0], d_done[0], stall[0]}), 32'b100);
        cin[0] = '0;
        din[0] = '0;
      end
    end
    // debug store then CPU load of the same word
    acc(0, PORT_DBG, 1'b1, BE_WORD, 16'hffe8, 32'd7, -1, 16'h0);
    chk("dst_done_cyc", r_cyc, 2);
    chk("dst_en_cyc", r_en_cyc, 1);
    chk("dst_en_n", r_en_n, 1);
    chk("dst_we", 32'(r_we), 32'hf);
    chk("dst_addr", 32'(r_a), 32'hffe8);
    chk("dst_wdata", r_wd, 7);
    chk("dst_other_done", 32'(r_od), 0);
    acc(0, PORT_CPU, 1'b0, BE_WORD, 16'hffe8, 32'h0, -1, 16'h0);
    chk("cld_done_cyc", r_cyc, 2);
    chk("cld_rdata", r_rd, 7);
    chk("cld_we", 32'(r_we), 0);
    // byte stores, big-endian lanes
    acc(0, PORT_DBG, 1'b1, BE_WORD, 16'hfff0, 32'h0, -1, 16'h0);
    acc(0, PORT_CPU, 1'b1, 4'b0010, 16'hfff0, 32'h0000AB00, -1, 16'h0);
    chk("bst_we", 32'(r_we), 32'b0010);
    acc(0, PORT_DBG, 1'b0, BE_WORD, 16'hfff0, 32'h0, -1, 16'h0);
    chk("bst_readback", r_rd, 32'h0000AB00);
    acc(0, PORT_DBG, 1'b1, BE_WORD, 16'hfff4, 32'h11223344, -1, 16'h0);
    acc(0, PORT_CPU, 1'b1, 4'b0100, 16'hfff4, 32'h00CC0000, -1, 16'h0);
    acc(0, PORT_DBG, 1'b0, BE_WORD, 16'hfff4, 32'h0, -1, 16'h0);
    chk("bst_lane1", r_rd, 32'h11CC3344);
    acc(0, PORT_CPU, 1'b1, 4'b0000, 16'hfff4, 32'hFFFFFFFF, -1, 16'h0);
    chk("be0_done_cyc", r_cyc, 2);
    chk("be0_en_n", r_en_n, 1);
    chk("be0_we", 32'(r_we), 0);
    acc(0, PORT_DBG, 1'b0, BE_WORD, 16'hfff4, 32'h0, -1, 16'h0);
    chk("be0_unchanged", r_rd, 32'h11CC3344);
    // latency sweep across the three instances
    for (int k = 0; k < 3; k++) begin
      acc(k, PORT_DBG, 1'b1, BE_WORD, 16'hffe8, 32'hA5A50000 | k, -1, 16'h0);
      chk($sformatf("lat%0d_st_cyc", lat[k]), r_cyc, 2 + lat[k]);
      chk($sformatf("lat%0d_st_en_n", lat[k]), r_en_n, 1);
      acc(k, PORT_DBG, 1'b1, BE_WORD, 16'hffec, 32'h5A5A0000 | k, -1, 16'h0);
      acc(k, PORT_CPU, 1'b0, BE_WORD, 16'hffe8, 32'h0, -1, 16'h0);
      chk($sformatf("lat%0d_ld_cyc", lat[k]), r_cyc, 2 + lat[k]);
      chk($sformatf("lat%0d_ld_rdata", lat[k]), r_rd, 32'hA5A50000 | k);
      chk($sformatf("lat%0d_ld_en_cyc", lat[k]), r_en_cyc, 1);
    end
    // reset in the middle of WAIT on the MEM_LAT=3 instance
    tick;
    cin[2] = {1'b1, 1'b0, BE_WORD, 16'hffec, 32'h0};
    repeat (3) tick;
    chk("mid_busy_before", 32'(busy[2]), 1);
    rst[2] = 1'b1;
    #1;
    chk("mid_busy", 32'(busy[2]), 0);
    chk("mid_mem", 32'({men[2], mwe[2]}), 0);
    chk("mid_addr", 32'(maddr[2]), 0);
    chk("mid_rdata", c_rd[2], 0);
    chk("mid_done", 32'(c_done[2]), 0);
    cin[2] = '0;
    tick;
    rst[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      tick;
      if (c_done[2] | d_done[2]) seen = 1'b1;
    end
    chk("mid_no_done", 32'(seen), 0);
    acc(2, PORT_CPU, 1'b0, BE_WORD, 16'hffec, 32'h0, -1, 16'h0);
    chk("mid_reissue_cyc", r_cyc, 5);
    chk("mid_reissue_rdata", r_rd, 32'h5A5A0002);
    // fields changed after the grant are ignored; the other port's rdata holds
    acc(2, PORT_DBG, 1'b0, BE_WORD, 16'hffec, 32'h0, -1, 16'h0);
    chk("chg_dbg_rdata", r_rd, 32'h5A5A0002);
    acc(2, PORT_CPU, 1'b0, BE_WORD, 16'hffe8, 32'h0, 2, 16'hffec);
    chk("chg_cyc", r_cyc, 5);
    chk("chg_addr", 32'(r_a), 32'hffe8);
    chk("chg_rdata", r_rd, 32'hA5A50002);
    chk("chg_dbg_hold", d_rd[2], 32'h5A5A0002);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
